// File: rtl/matrix_io_pkg.sv
// Shared types for the matrix I/O controller: the two-state frame FSM encoding.
package matrix_io_pkg;

  typedef enum logic {
    FILL = 1'b0,
    SHOW = 1'b1
  } state_e;

endpackage

// File: rtl/word_buf.sv
// Frame buffer: one synchronous write port, combinational read by index.
// Contents are not reset; a frame is only shown after every slot is rewritten.
module word_buf #(
  parameter int width_p  = 8,
  parameter int depth_p  = 4,
  parameter int addr_w_p = 2
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [addr_w_p-1:0] waddr_i,
  input  logic [width_p-1:0]  wdata_i,
  input  logic [addr_w_p-1:0] raddr_i,
  output logic [width_p-1:0]  rdata_o
);

  logic [width_p-1:0] mem [depth_p];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/matrix_io_ctrl.sv
// Serial-in frame collector that replays each buffered word for hold_cycles_p cycles.
// Define MATRIX_IO_LOOP_EN to replay the frame forever instead of returning to FILL.
module matrix_io_ctrl
  import matrix_io_pkg::*;
#(
  parameter int width_p       = 8,
  parameter int depth_p       = 4,
  parameter int hold_cycles_p = 60000000
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  input  logic                       bit_valid_i,
  input  logic                       bit_i,
  output logic                       bit_ready_o,
  output logic [width_p-1:0]         word_o,
  output logic                       show_o,
  output logic [$clog2(depth_p)-1:0] index_o,
  output logic                       word_done_o,
  output logic                       new_show_o,
  output state_e                     state_o
);

  localparam int CW = $clog2(width_p);
  localparam int IW = $clog2(depth_p);
  localparam int HW = (hold_cycles_p > 1) ? $clog2(hold_cycles_p) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(width_p - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(depth_p - 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(hold_cycles_p - 1);

  state_e             state_q, state_d;
  logic [width_p-1:0] shift_q, shift_d, shifted;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               done_q, done_d;
  logic               new_q, new_d;
  logic               we;
  logic [width_p-1:0] rd_data;

  // Handshake: a bit is consumed on a posedge exactly when bit_valid_i and
  // bit_ready_o are both high; offers while not ready are dropped, never queued.
  assign bit_ready_o = (state_q == FILL);
  assign shifted     = {shift_q[width_p-2:0], bit_i};

  word_buf #(.width_p(width_p), .depth_p(depth_p), .addr_w_p(IW)) u_buf (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (idx_q),
    .wdata_i (shifted),
    .raddr_i (idx_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    new_d   = 1'b0;
    we      = 1'b0;
    if (clear_i) begin
      state_d = FILL;
      shift_d = '0;
      cnt_d   = '0;
      idx_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (bit_valid_i) begin
            if (cnt_q == LAST_BIT) begin
              we      = 1'b1;
              done_d  = 1'b1;
              cnt_d   = '0;
              shift_d = '0;
              if (idx_q == LAST_IDX) begin
                state_d = SHOW;
                idx_d   = '0;
                hold_d  = '0;
                new_d   = 1'b1;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end else begin
              cnt_d   = cnt_q + 1'b1;
              shift_d = shifted;
            end
          end
        end
        SHOW: begin
          if (hold_q == LAST_HOLD) begin
            hold_d = '0;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
`ifdef MATRIX_IO_LOOP_EN
              new_d = 1'b1;
`else
              state_d = FILL;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
              new_d = 1'b1;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= FILL;
      shift_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      new_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      new_q   <= new_d;
    end
  end

  assign show_o      = (state_q == SHOW);
  assign word_o      = show_o ? rd_data : shift_q;
  assign index_o     = idx_q;
  assign word_done_o = done_q;
  assign new_show_o  = new_q;
  assign state_o     = state_q;

endmodule

// File: doc/matrix_io_ctrl.md
MATRIX_IO_CTRL -- requirements
Module: matrix_io_ctrl

Interface
REQ-001 Parameter width_p, default 8, word width in bits (>=2).
REQ-002 Parameter depth_p, default 4, words buffered per frame (>=2).
REQ-003 Parameter hold_cycles_p, default 60000000, clk_i cycles each buffered word is shown (>=1).
REQ-004 clk_i  input  1  sole clock; all state updates on posedge.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 clear_i  input  1  synchronous abort: discard frame, return to FILL.
REQ-007 bit_valid_i  input  1  one serial bit offered this cycle.
REQ-008 bit_i  input  1  serial data bit.
REQ-009 bit_ready_o  output  1  high in FILL; bits accepted only when bit_valid_i & bit_ready_o.
REQ-010 word_o  output  width_p  FILL: partial shift register; SHOW: buffered word at index_o.
REQ-011 show_o  output  1  high in SHOW state.
REQ-012 index_o  output  $clog2(depth_p)  FILL: words stored; SHOW: word being shown.
REQ-013 word_done_o  output  1  one-cycle pulse when a completed word enters the buffer.
REQ-014 new_show_o  output  1  one-cycle pulse each cycle word_o switches to a new buffered word.

Function
REQ-015 States FILL and SHOW only; reset state FILL.
REQ-016 Accepted bit: shift register <= {shift[width_p-2:0], bit_i}; first bit of a word ends at MSB.
REQ-017 On the width_p-th accepted bit the complete word (including that bit) is written to buffer[index] at the same edge, word_done_o pulses next cycle, bit count and shift register clear to 0.
REQ-018 Writing word depth_p-1: next cycle state=SHOW, index_o=0, hold counter=0, new_show_o pulses, word_o=buffer[0].
REQ-019 SHOW: hold counter increments every cycle; at hold_cycles_p-1 it wraps to 0 and index_o increments, new_show_o pulses.
REQ-020 SHOW, last index at terminal hold count: state=FILL, index_o=0, word_o=0 (no pulse).
REQ-021 Bits offered in SHOW are dropped, not queued; bit_ready_o low.
REQ-022 clear_i wins over every simultaneous event: next cycle FILL, index 0, bit count 0, shift register 0, hold counter 0, no pulses; buffer contents need not be cleared.
REQ-023 Partial word (fewer than width_p bits) persists indefinitely across idle cycles.
REQ-024 Counters sized for their max value; no overflow with hold_cycles_p=1 (new word each cycle).

Reset
REQ-025 reset_i asserted: state FILL, bit_ready_o=1, word_o=0, show_o=0, index_o=0, word_done_o=0, new_show_o=0, all counters 0, immediately and asynchronously.
REQ-026 Reset deassertion mid-frame: behaviour identical to a fresh start; no pre-reset word shown.

Configuration
REQ-027 Macro MATRIX_IO_LOOP_EN defined: at REQ-020 point index wraps to 0, new_show_o pulses, state stays SHOW; exit only via clear_i or reset_i.
REQ-028 MATRIX_IO_LOOP_EN undefined: REQ-020 applies, one pass then FILL.

Structure
REQ-029 Package matrix_io_pkg holds state enum typedef (FILL, SHOW) only; widths derive from parameters locally.
REQ-030 Buffer is sub-module word_buf (width_p x depth_p, one synchronous write port, combinational read by index); FSM, shift register, counters in matrix_io_ctrl.

Verification (width_p=8, depth_p=4, hold_cycles_p=3)
REQ-031 Reset -> all outputs per REQ-025; 8 bits 1,0,1,0,0,1,0,1 -> word_done_o pulse, buffer[0]=0xA5, index_o=1.
REQ-032 Words 0x11,0x22,0x33,0x44 -> show_o rises; word_o 0x11,0x22,0x33,0x44 each exactly 3 cycles, 4 new_show_o pulses; then FILL, word_o=0.
REQ-033 Bits driven continuously during SHOW -> bit_ready_o=0, after return index_o=0, word_o=0.
REQ-034 3 bits then clear_i with bit_valid_i high -> word_o=0, index_o=0, no word_done_o.
REQ-035 MATRIX_IO_LOOP_EN, same 4 words -> sequence 0x11..0x44,0x11 continues until clear_i; clear -> FILL next cycle.
REQ-036 reset_i pulsed asynchronously mid-SHOW -> outputs per REQ-025 before next posedge.
